// File: rtl/dcache_ctrl_if.sv
// CPU load/store port and memblock line port of the data cache.
// slave is the cache side; master is the CPU plus memory side.
interface dcache_ctrl_if;
    logic         cpu_rd;
    logic         cpu_wr;
    logic [31:0]  cpu_addr;
    logic [63:0]  cpu_wdata;
    logic [63:0]  cpu_rdata;
    logic         cpu_stall;
    logic         blockread;
    logic         blockwrite;
    logic [31:0]  blockaddr;
    logic [255:0] writeblock;
    logic [255:0] readblock;
    logic         ready;

    modport slave (
        input  cpu_rd,
        input  cpu_wr,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_rdata,
        output cpu_stall,
        output blockread,
        output blockwrite,
        output blockaddr,
        output writeblock,
        input  readblock,
        input  ready
    );

    modport master (
        output cpu_rd,
        output cpu_wr,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_rdata,
        input  cpu_stall,
        input  blockread,
        input  blockwrite,
        input  blockaddr,
        input  writeblock,
        output readblock,
        output ready
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache in front of memblock.
// Hits complete with zero stall; misses write back a dirty victim, then fetch.
module dcache_ctrl #(
    parameter int INDEX_BITS = 3
) (
    input  logic  clk,
    input  logic  reset_n,
    dcache_ctrl_if.slave bus
);
    localparam int TAG_BITS = 32 - 5 - INDEX_BITS;
    localparam int NLINES   = 1 << INDEX_BITS;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WB      = 2'd1;
    localparam logic [1:0] RD_REQ  = 2'd2;
    localparam logic [1:0] RD_WAIT = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nx;

    logic [255:0]          data_q [NLINES];
    logic [TAG_BITS-1:0]   tag_q  [NLINES];
    logic [NLINES-1:0]     valid_q;
    logic [NLINES-1:0]     dirty_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            word;
    logic [7:0]            woff;
    logic [255:0]          line;
    logic [255:0]          store_line;
    logic                  req;
    logic                  hit;
    logic                  store_hit;
    logic                  wb_done;
    logic                  fill;
    logic                  unused_addr;

    assign idx  = bus.cpu_addr[5 +: INDEX_BITS];
    assign tag  = bus.cpu_addr[31 -: TAG_BITS];
    assign word = bus.cpu_addr[4:3];
    // word0 lives in the top 64 bits, so the offset is (3-word)*64
    assign woff = {~word, 6'b0};
    assign line = data_q[idx];

    assign unused_addr = ^bus.cpu_addr[2:0];

    assign req       = bus.cpu_rd | bus.cpu_wr;
    assign hit       = valid_q[idx] & (tag_q[idx] == tag);
    assign store_hit = (state == IDLE) & bus.cpu_wr & hit;
    assign wb_done   = (state == WB) & bus.ready;
    assign fill      = (state == RD_WAIT) & bus.ready;

    always_comb begin
        store_line = line;
        store_line[woff +: 64] = bus.cpu_wdata;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_nx = (valid_q[idx] && dirty_q[idx]) ? WB : RD_REQ;
                end
            end
            WB: begin
                if (bus.ready) state_nx = RD_REQ;
            end
            RD_REQ: begin
                if (bus.ready) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.cpu_rdata  = line[woff +: 64];
    assign bus.cpu_stall  = (state != IDLE) | (req & ~hit);
    // gating on ready keeps a still-busy memory from being re-triggered
    assign bus.blockread  = (state == RD_REQ) & bus.ready;
    assign bus.blockwrite = (state == WB) & bus.ready;
    assign bus.writeblock = line;

    always_comb begin
        if (state == WB) begin
            bus.blockaddr = {5'b0, tag_q[idx], idx};
        end else begin
            bus.blockaddr = {5'b0, bus.cpu_addr[31:5]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state <= state_nx;
            if (store_hit) begin
                dirty_q[idx] <= 1'b1;
            end
            if (wb_done) begin
                dirty_q[idx] <= 1'b0;
            end
            if (fill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_hit) begin
            data_q[idx] <= store_line;
        end else if (fill) begin
            data_q[idx] <= bus.readblock;
            tag_q[idx]  <= tag;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl against a 20-cycle memblock model.
// Memory word w of block b reads as {A5A50000+b, w} until written back.
module tb_dcache_ctrl;
    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_err;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.INDEX_BITS(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [255:0] wmem [logic [31:0]];
    logic         mem_ready = 1'b1;
    logic [255:0] mem_rblk  = '0;
    int           cnt       = 0;
    int           rd_cnt    = 0;
    int           rd_busy   = 0;
    int           wr_cnt    = 0;
    logic [31:0]  rd_addr   = '0;
    logic [31:0]  wr_addr   = '0;
    logic [255:0] wr_blk    = '0;

    assign bus.ready     = mem_ready;
    assign bus.readblock = mem_rblk;

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [31:0] hi;
        hi = 32'hA5A5_0000 + a;
        if (wmem.exists(a)) return wmem[a];
        return {hi, 32'd0, hi, 32'd1, hi, 32'd2, hi, 32'd3};
    endfunction

    // memory keeps counting through a cache reset
    always @(posedge clk) begin
        if (bus.blockwrite) begin
            wmem[bus.blockaddr] = bus.writeblock;
            wr_cnt  = wr_cnt + 1;
            wr_addr = bus.blockaddr;
            wr_blk  = bus.writeblock;
        end
        if (bus.blockread) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = bus.blockaddr;
            if (!mem_ready) rd_busy = rd_busy + 1;
            mem_rblk  <= mem_line(bus.blockaddr);
            mem_ready <= 1'b0;
            cnt       <= 19;
        end else if (cnt == 1) begin
            mem_ready <= 1'b1;
            cnt       <= 0;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_req(input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           output int stalls, output logic [63:0] rdata);
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.cpu_stall) break;
            stalls++;
        end
        rdata = bus.cpu_rdata;
        @(posedge clk);
        #1;
        bus.cpu_rd = 1'b0;
        bus.cpu_wr = 1'b0;
    endtask

    int          st;
    logic [63:0] rd;

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n       = 1'b0;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        @(negedge clk);
        chk("rst_stall", 256'(bus.cpu_stall), 256'(0));
        chk("rst_bread", 256'(bus.blockread), 256'(0));
        chk("rst_bwrite", 256'(bus.blockwrite), 256'(0));
        chk("rst_valid", 256'(dut.valid_q), 256'(0));
        @(posedge clk);
        #1 reset_n = 1'b1;

        cpu_req(1, 0, 32'h0000_0000, '0, st, rd);
        chk("miss0_stall", 256'(st), 256'(22));
        chk("miss0_data", 256'(rd), 256'(64'hA5A50000_00000000));
        chk("miss0_rdcnt", 256'(rd_cnt), 256'(1));
        chk("miss0_rdaddr", 256'(rd_addr), 256'(0));

        cpu_req(1, 0, 32'h0000_0008, '0, st, rd);
        chk("hit1", {192'(st), rd}, {192'(0), 64'hA5A50000_00000001});
        cpu_req(1, 0, 32'h0000_0010, '0, st, rd);
        chk("hit2", {192'(st), rd}, {192'(0), 64'hA5A50000_00000002});
        cpu_req(1, 0, 32'h0000_0018, '0, st, rd);
        chk("hit3", {192'(st), rd}, {192'(0), 64'hA5A50000_00000003});
        chk("hit_rdcnt", 256'(rd_cnt), 256'(1));

        cpu_req(0, 1, 32'h0000_0008, 64'hDEADBEEF_CAFEF00D, st, rd);
        chk("st_hit_stall", 256'(st), 256'(0));
        cpu_req(1, 0, 32'h0000_0008, '0, st, rd);
        chk("st_hit_rd", {192'(st), rd}, {192'(0), 64'hDEADBEEF_CAFEF00D});
        chk("st_hit_dirty", 256'(dut.dirty_q[0]), 256'(1));
        chk("st_hit_traffic", 256'({rd_cnt, wr_cnt}), 256'({32'd1, 32'd0}));

        cpu_req(1, 0, 32'h0000_0100, '0, st, rd);
        chk("dmiss_stall", 256'(st), 256'(23));
        chk("dmiss_wrcnt", 256'(wr_cnt), 256'(1));
        chk("dmiss_wraddr", 256'(wr_addr), 256'(0));
        chk("dmiss_wb_w1", 256'(wr_blk[191:128]), 256'(64'hDEADBEEF_CAFEF00D));
        chk("dmiss_wb_w0", 256'(wr_blk[255:192]), 256'(64'hA5A50000_00000000));
        chk("dmiss_rdaddr", 256'({rd_cnt, rd_addr}), 256'({32'd2, 32'd8}));
        chk("dmiss_data", 256'(rd), 256'(64'hA5A50008_00000000));

        cpu_req(0, 1, 32'h0000_0020, 64'h01234567_89ABCDEF, st, rd);
        chk("smiss_stall", 256'(st), 256'(22));
        chk("smiss_rdaddr", 256'({rd_cnt, rd_addr}), 256'({32'd3, 32'd1}));
        chk("smiss_dirty", 256'(dut.dirty_q[1]), 256'(1));
        cpu_req(1, 0, 32'h0000_0020, '0, st, rd);
        chk("smiss_rd0", {192'(st), rd}, {192'(0), 64'h01234567_89ABCDEF});
        cpu_req(1, 0, 32'h0000_0028, '0, st, rd);
        chk("smiss_rd1", {192'(st), rd}, {192'(0), 64'hA5A50001_00000001});

        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 32'h0000_0060;
        repeat (7) @(posedge clk);
        chk("abort_rdcnt", 256'(rd_cnt), 256'(4));
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        chk("abort_valid", 256'(dut.valid_q), 256'(0));
        cpu_req(1, 0, 32'h0000_0040, '0, st, rd);
        chk("abort_stall", 256'(st), 256'(35));
        chk("abort_busy", 256'(rd_busy), 256'(0));
        chk("abort_rdaddr", 256'({rd_cnt, rd_addr}), 256'({32'd5, 32'd2}));
        chk("abort_data", 256'(rd), 256'(64'hA5A50002_00000000));
        chk("abort_valid2", 256'(dut.valid_q), 256'(8'b0000_0100));

        cpu_req(1, 0, 32'h0000_0060, '0, st, rd);
        chk("refetch_stall", 256'(st), 256'(22));
        chk("refetch_data", 256'(rd), 256'(64'hA5A50003_00000000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
